serial_port_controller: RTL and testbench
=========================================

# serial_port_controller

Memory-mapped controller that sequences the processor's external byte-serial port. Sits between the datapath's load/store path and the serial pins: buffers outbound bytes in a TX FIFO, prefetches inbound bytes into an RX FIFO, generates single-cycle `serial_wren_out`/`serial_rden_out` strobes, and stalls the core on blocking accesses.

## Interface
- `TX_DEPTH`, 4: TX FIFO entries (power of two, ≥2).
- `RX_DEPTH`, 4: RX FIFO entries (power of two, ≥2).
- `clock` in 1: the only clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clock` rising edge.
- `cpu_addr` in 1: 0 = DATA register, 1 = STATUS register.
- `cpu_re` in 1: load request, level, held until not stalled.
- `cpu_we` in 1: store request, level, held until not stalled.
- `cpu_wdata` in 8: byte to transmit on DATA store.
- `cpu_rdata` out 32: load result, zero-extended, combinational.
- `cpu_stall` out 1: freeze PC/pipeline this cycle, combinational.
- `serial_in` in 8: inbound byte, valid while `serial_valid_in` high.
- `serial_valid_in` in 1: external source holds a byte.
- `serial_ready_in` in 1: external sink can accept a byte.
- `serial_out` out 8: outbound byte, valid with `serial_wren_out`.
- `serial_rden_out` out 1: one-cycle pop strobe to source.
- `serial_wren_out` out 1: one-cycle push strobe to sink.

## Operation
- CPU side (counts below are registered values at cycle start):
  - DATA store, TX not full: push `cpu_wdata`, `cpu_stall`=0.
  - DATA store, TX full: `cpu_stall`=1, no push; a drain pop in the same cycle does not admit the push (push lands next cycle).
  - DATA load, RX not empty: `cpu_rdata`={24'b0, RX head}, pop at edge, `cpu_stall`=0.
  - DATA load, RX empty: `cpu_stall`=1, `cpu_rdata`=0; a capture in the same cycle makes the byte readable next cycle.
  - STATUS load: never stalls; `cpu_rdata` bit0 = RX not empty, bit1 = TX not full, bit2 = TX empty, bits[10:8] = RX count, bits[18:16] = TX count, all other bits 0.
  - STATUS store: ignored, no stall.
  - `cpu_re` and `cpu_we` both high: `cpu_we` wins, load ignored.
  - Neither asserted: `cpu_stall`=0, `cpu_rdata`=0.
- TX FSM: states TX_IDLE, TX_WAIT.
  - TX_IDLE: if TX not empty and `serial_ready_in`, assert `serial_wren_out`, drive `serial_out`=TX head, pop, go TX_WAIT. Otherwise stay.
  - TX_WAIT: strobes low, unconditionally return to TX_IDLE (one dead cycle lets the sink update ready).
- RX FSM: states RX_IDLE, RX_WAIT.
  - RX_IDLE: if `serial_valid_in` and RX not full, assert `serial_rden_out`, capture `serial_in` into RX tail, go RX_WAIT.
  - RX_WAIT: strobe low, return to RX_IDLE.
  - RX full: no strobe, external byte left pending; overflow impossible by construction.
- FIFOs: circular buffers, pointer width log2(DEPTH), wrap modulo DEPTH; count width log2(DEPTH)+1. Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- `serial_out` holds last transmitted byte between strobes.

## Timing
- Reset (`reset`=0 at edge): FIFOs empty, pointers 0, FSMs IDLE, `serial_out`=0, both strobes 0. Combinational outputs then read `cpu_stall`=0 (if no request), `cpu_rdata`=0. Reset mid-transfer discards all buffered bytes; no strobe in the following cycle.
- Store-to-pin latency, empty TX, sink ready: store at edge N, `serial_wren_out` high in cycle N+1.
- Max TX throughput: one byte per 2 cycles. Max RX throughput: one byte per 2 cycles.
- Pin-to-load latency: `serial_rden_out` in cycle M, byte readable by a DATA load in cycle M+1.
- A stalled load or store completes in the first cycle its FIFO condition holds; exactly one push or pop per completed access.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `serial_valid_in`=1 and `serial_ready_in`=1 -> strobes 0, `serial_out`=0; STATUS read after release = 0x00000006.
- TX burst: 5 stores 0x11..0x55 back-to-back, `serial_ready_in`=0 -> 5th store stalls, STATUS bits[18:16]=4; raise ready -> `serial_wren_out` every 2nd cycle, bytes 0x11,0x22,0x33,0x44,0x55 in order, 5th store admitted one cycle after first pop.
- RX blocking load: DATA load with RX empty -> `cpu_stall`=1; assert `serial_valid_in` with 0xA5 -> `serial_rden_out` one cycle, load completes next cycle with `cpu_rdata`=0x000000A5.
- RX full: `serial_valid_in` held high, 6 distinct bytes offered, no loads -> exactly 4 `serial_rden_out` strobes, STATUS bits[10:8]=4; 4 loads return bytes in order, then the 5th byte is fetched.
- Wrap-around: 10 store/drain cycles of 0x00..0x09 -> pins see 0x00..0x09 in order, pointers wrap twice, TX empty at end.
- Simultaneous: `cpu_re`=`cpu_we`=1 on DATA -> store performed, RX count unchanged.

Source files
------------

// File: rtl/serial_port_controller.sv
// serial_port_controller
//
// Memory-mapped controller for the processor's byte-serial port. Outbound
// bytes stored to DATA are queued in a TX FIFO and handed to the sink one
// strobe at a time. Inbound bytes are prefetched from the source into an RX
// FIFO and returned by DATA loads. STATUS reports the FIFO levels. Accesses
// that cannot complete (store to a full TX FIFO, load from an empty RX FIFO)
// stall the core until they can.
//
// Ports:
//   clock, reset        - single clock, synchronous active-low reset
//   cpu_addr            - 0 = DATA, 1 = STATUS
//   cpu_re / cpu_we     - level load / store requests (store wins)
//   cpu_wdata           - byte to transmit
//   cpu_rdata           - zero-extended load result (combinational)
//   cpu_stall           - freeze the core this cycle (combinational)
//   serial_in           - inbound byte, valid with serial_valid_in
//   serial_valid_in     - source holds a byte
//   serial_ready_in     - sink can accept a byte
//   serial_out          - outbound byte, valid with serial_wren_out
//   serial_rden_out     - one-cycle pop strobe to the source
//   serial_wren_out     - one-cycle push strobe to the sink
module serial_port_controller #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_addr,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic [7:0]  serial_in,
    input  logic        serial_valid_in,
    input  logic        serial_ready_in,
    output logic [7:0]  serial_out,
    output logic        serial_rden_out,
    output logic        serial_wren_out
);

    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_PW + 1;
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_PW + 1;

    typedef enum logic {TX_IDLE, TX_WAIT} txState_e;
    typedef enum logic {RX_IDLE, RX_WAIT} rxState_e;

    logic [7:0]       r_txMem [TX_DEPTH];
    logic [TX_PW-1:0] r_txWrPtr;
    logic [TX_PW-1:0] r_txRdPtr;
    logic [TX_CW-1:0] r_txCount;
    txState_e         r_txState;
    txState_e         w_txNext;
    logic [7:0]       r_lastOut;

    logic [7:0]       r_rxMem [RX_DEPTH];
    logic [RX_PW-1:0] r_rxWrPtr;
    logic [RX_PW-1:0] r_rxRdPtr;
    logic [RX_CW-1:0] r_rxCount;
    rxState_e         r_rxState;
    rxState_e         w_rxNext;

    logic w_txFull, w_txEmpty, w_rxFull, w_rxEmpty;
    logic w_dataWr, w_dataRd, w_statRd;
    logic w_txPush, w_txPop, w_rxPush, w_rxPop;

    // FIFO flags come from the registered counts, so a pop or capture in
    // the current cycle only helps a blocked access on the next cycle.
    assign w_txFull  = (r_txCount == TX_CW'(TX_DEPTH));
    assign w_txEmpty = (r_txCount == '0);
    assign w_rxFull  = (r_rxCount == RX_CW'(RX_DEPTH));
    assign w_rxEmpty = (r_rxCount == '0);

    // Store takes priority over load when both are requested.
    assign w_dataWr = cpu_we & ~cpu_addr;
    assign w_dataRd = cpu_re & ~cpu_we & ~cpu_addr;
    assign w_statRd = cpu_re & ~cpu_we & cpu_addr;

    assign w_txPush  = w_dataWr & ~w_txFull;
    assign w_rxPop   = w_dataRd & ~w_rxEmpty;
    assign cpu_stall = (w_dataWr & w_txFull) | (w_dataRd & w_rxEmpty);

    // Load result: RX head on a completing DATA load, status word on a
    // STATUS load, zero otherwise (including a stalled DATA load).
    always_comb begin
        cpu_rdata = '0;
        if (w_rxPop) begin
            cpu_rdata[7:0] = r_rxMem[r_rxRdPtr];
        end else if (w_statRd) begin
            cpu_rdata[0]     = ~w_rxEmpty;
            cpu_rdata[1]     = ~w_txFull;
            cpu_rdata[2]     = w_txEmpty;
            cpu_rdata[10:8]  = 3'(r_rxCount);
            cpu_rdata[18:16] = 3'(r_txCount);
        end
    end

    // TX FSM: the strobe is issued from IDLE and followed by one dead cycle
    // so the sink has time to update its ready. Strobes are gated by reset so
    // nothing reaches the pins while reset is held.
    always_comb begin
        w_txNext = r_txState;
        w_txPop  = 1'b0;
        case (r_txState)
            TX_IDLE: begin
                if (reset && !w_txEmpty && serial_ready_in) begin
                    w_txPop  = 1'b1;
                    w_txNext = TX_WAIT;
                end
            end
            TX_WAIT: w_txNext = TX_IDLE;
            default: w_txNext = TX_IDLE;
        endcase
    end

    assign serial_wren_out = w_txPop;
    assign serial_out      = w_txPop ? r_txMem[r_txRdPtr] : r_lastOut;

    // RX FSM: same two-cycle rhythm as TX; a full RX FIFO leaves the byte
    // pending at the source, so the FIFO can never overflow.
    always_comb begin
        w_rxNext = r_rxState;
        w_rxPush = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                if (reset && serial_valid_in && !w_rxFull) begin
                    w_rxPush = 1'b1;
                    w_rxNext = RX_WAIT;
                end
            end
            RX_WAIT: w_rxNext = RX_IDLE;
            default: w_rxNext = RX_IDLE;
        endcase
    end

    assign serial_rden_out = w_rxPush;

    // TX pointers, count, state and the held output byte.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_txWrPtr <= '0;
            r_txRdPtr <= '0;
            r_txCount <= '0;
            r_txState <= TX_IDLE;
            r_lastOut <= '0;
        end else begin
            r_txState <= w_txNext;
            if (w_txPush) begin
                r_txWrPtr <= r_txWrPtr + TX_PW'(1);
            end
            if (w_txPop) begin
                r_txRdPtr <= r_txRdPtr + TX_PW'(1);
                r_lastOut <= r_txMem[r_txRdPtr];
            end
            case ({w_txPush, w_txPop})
                2'b10:   r_txCount <= r_txCount + TX_CW'(1);
                2'b01:   r_txCount <= r_txCount - TX_CW'(1);
                default: r_txCount <= r_txCount;
            endcase
        end
    end

    // TX storage needs no reset; the count alone defines what is valid.
    always_ff @(posedge clock) begin
        if (reset && w_txPush) begin
            r_txMem[r_txWrPtr] <= cpu_wdata;
        end
    end

    // RX pointers, count and state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rxWrPtr <= '0;
            r_rxRdPtr <= '0;
            r_rxCount <= '0;
            r_rxState <= RX_IDLE;
        end else begin
            r_rxState <= w_rxNext;
            if (w_rxPush) begin
                r_rxWrPtr <= r_rxWrPtr + RX_PW'(1);
            end
            if (w_rxPop) begin
                r_rxRdPtr <= r_rxRdPtr + RX_PW'(1);
            end
            case ({w_rxPush, w_rxPop})
                2'b10:   r_rxCount <= r_rxCount + RX_CW'(1);
                2'b01:   r_rxCount <= r_rxCount - RX_CW'(1);
                default: r_rxCount <= r_rxCount;
            endcase
        end
    end

    // RX storage captures the inbound byte on the pop strobe.
    always_ff @(posedge clock) begin
        if (w_rxPush) begin
            r_rxMem[r_rxWrPtr] <= serial_in;
        end
    end

endmodule

// File: tb/tb_serial_port_controller.sv
// tb_serial_port_controller
//
// Drives the serial port controller through directed scenarios followed by a
// randomized phase. A queue-based reference model predicts every output in
// every cycle from the FIFO contents and the pacing rules of the port.
module tb_serial_port_controller;

    localparam int TXD = 4;
    localparam int RXD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_addr = 1'b0;
    logic        cpu_re = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [7:0]  serial_in = 8'h00;
    logic        serial_valid_in = 1'b0;
    logic        serial_ready_in = 1'b0;
    logic [7:0]  serial_out;
    logic        serial_rden_out;
    logic        serial_wren_out;

    serial_port_controller #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clock(clock),
        .reset(reset),
        .cpu_addr(cpu_addr),
        .cpu_re(cpu_re),
        .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .serial_in(serial_in),
        .serial_valid_in(serial_valid_in),
        .serial_ready_in(serial_ready_in),
        .serial_out(serial_out),
        .serial_rden_out(serial_rden_out),
        .serial_wren_out(serial_wren_out)
    );

    always #5 clock = ~clock;

    int nChecks = 0;
    int nFails = 0;

    // Reference model state: FIFO contents as queues, plus whether each pin
    // side moved a byte last cycle (which forces a dead cycle now).
    byte unsigned txQ[$];
    byte unsigned rxQ[$];
    bit           txDead = 1'b0;
    bit           rxDead = 1'b0;
    bit           known = 1'b0;
    logic [7:0]   lastOut = 8'h00;
    bit           mDone = 1'b0;
    bit           mRden = 1'b0;
    int           rdenSeen = 0;

    // Byte source used by the RX scenarios: advances on each predicted pop.
    byte unsigned srcBytes[6] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    bit           srcActive = 1'b0;
    int           srcIdx = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit re, input bit we, input bit addr, input logic [7:0] wd);
        cpu_re    = re;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
    endtask

    // Check all outputs before the edge, then advance the model across it.
    task automatic checkOutput();
        bit          dataWr, dataRd, statRd, txFull, txEmpty, rxEmpty;
        bit          expStall, expWren, expRden;
        logic [31:0] expRdata;
        logic [7:0]  expOut, sIn, wd;
        bit          rstNow, weAddr;
        @(negedge clock);
        txFull  = (txQ.size() == TXD);
        txEmpty = (txQ.size() == 0);
        rxEmpty = (rxQ.size() == 0);
        dataWr  = cpu_we && !cpu_addr;
        dataRd  = cpu_re && !cpu_we && !cpu_addr;
        statRd  = cpu_re && !cpu_we && cpu_addr;
        weAddr  = cpu_we && cpu_addr;
        rstNow  = !reset;
        sIn     = serial_in;
        wd      = cpu_wdata;
        expWren = !rstNow && !txDead && !txEmpty && serial_ready_in;
        expRden = !rstNow && !rxDead && serial_valid_in && (rxQ.size() < RXD);
        expStall = (dataWr && txFull) || (dataRd && rxEmpty);
        expRdata = 32'h0;
        if (dataRd && !rxEmpty) begin
            expRdata = 32'(rxQ[0]);
        end else if (statRd) begin
            expRdata = 32'(!rxEmpty) + 32'(!txFull) * 2 + 32'(txEmpty) * 4
                     + 32'(rxQ.size()) * 256 + 32'(txQ.size()) * 65536;
        end
        expOut = expWren ? txQ[0] : lastOut;
        checkVal("wren", serial_wren_out, expWren);
        checkVal("rden", serial_rden_out, expRden);
        if (known) begin
            checkVal("stall", cpu_stall, expStall);
            checkVal("rdata", cpu_rdata, expRdata);
            checkVal("serialOut", serial_out, expOut);
        end
        rdenSeen += int'(serial_rden_out);
        @(posedge clock);
        if (rstNow) begin
            txQ.delete();
            rxQ.delete();
            txDead  = 1'b0;
            rxDead  = 1'b0;
            lastOut = 8'h00;
            known   = 1'b1;
            mDone   = 1'b0;
            mRden   = 1'b0;
        end else begin
            if (expWren) lastOut = txQ.pop_front();
            if (dataWr && !txFull) txQ.push_back(wd);
            if (dataRd && !rxEmpty) void'(rxQ.pop_front());
            if (expRden) rxQ.push_back(sIn);
            txDead = expWren;
            rxDead = expRden;
            mRden  = expRden;
            mDone  = (dataWr && !txFull) || (dataRd && !rxEmpty) || statRd || weAddr;
        end
        #1;
        if (srcActive && mRden) begin
            srcIdx++;
            if (srcIdx < 6) serial_in = srcBytes[srcIdx];
            else serial_valid_in = 1'b0;
        end
    endtask

    // Hold one CPU request until the model says it has completed.
    task automatic access(input bit re, input bit we, input bit addr, input logic [7:0] wd);
        int n = 0;
        applyStimulus(re, we, addr, wd);
        do begin
            checkOutput();
            n++;
        end while (!mDone && n < 40);
        checkVal("accessDone", 32'(mDone), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        // Reset held two cycles with both pin handshakes active.
        reset = 1'b0;
        serial_valid_in = 1'b1;
        serial_ready_in = 1'b1;
        serial_in = 8'h77;
        repeat (2) checkOutput();
        reset = 1'b1;
        serial_valid_in = 1'b0;
        serial_ready_in = 1'b0;
        access(1'b1, 1'b0, 1'b1, 8'h00);

        // TX burst with the sink not ready: four fill, fifth stalls.
        for (int i = 1; i <= 4; i++) access(1'b0, 1'b1, 1'b0, 8'(i * 8'h11));
        access(1'b1, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h55);
        repeat (2) checkOutput();
        serial_ready_in = 1'b1;
        access(1'b0, 1'b1, 1'b0, 8'h55);
        repeat (12) checkOutput();
        serial_ready_in = 1'b0;

        // Blocking load from an empty RX FIFO.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (2) checkOutput();
        serial_valid_in = 1'b1;
        serial_in = 8'hA5;
        checkOutput();
        serial_valid_in = 1'b0;
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput();

        // RX fill with six bytes offered and no loads: exactly four fetched.
        srcIdx = 0;
        serial_in = srcBytes[0];
        serial_valid_in = 1'b1;
        srcActive = 1'b1;
        rdenSeen = 0;
        repeat (14) checkOutput();
        checkVal("rxFullStrobes", 32'(rdenSeen), 32'd4);
        access(1'b1, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) access(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (6) checkOutput();
        while (rxQ.size() > 0) access(1'b1, 1'b0, 1'b0, 8'h00);
        srcActive = 1'b0;
        serial_valid_in = 1'b0;
        checkOutput();

        // Wrap-around: ten bytes through the TX FIFO with the sink ready.
        serial_ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            access(1'b0, 1'b1, 1'b0, 8'(i));
            repeat (2) checkOutput();
        end
        repeat (4) checkOutput();
        access(1'b1, 1'b0, 1'b1, 8'h00);
        serial_ready_in = 1'b0;

        // Load and store together: store wins, RX untouched.
        serial_valid_in = 1'b1;
        serial_in = 8'h3C;
        checkOutput();
        serial_valid_in = 1'b0;
        checkOutput();
        access(1'b1, 1'b1, 1'b0, 8'h99);
        access(1'b1, 1'b0, 1'b1, 8'h00);
        access(1'b1, 1'b0, 1'b0, 8'h00);
        serial_ready_in = 1'b1;
        repeat (4) checkOutput();

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            reset           = ($urandom_range(63) != 0);
            cpu_re          = 1'($urandom);
            cpu_we          = ($urandom_range(2) == 0);
            cpu_addr        = ($urandom_range(3) == 0);
            cpu_wdata       = 8'($urandom);
            serial_in       = 8'($urandom);
            serial_valid_in = 1'($urandom);
            serial_ready_in = 1'($urandom);
            checkOutput();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
